// File: rtl/mdr_mem_unit_pkg.sv
// Shared CPU datapath package: default bus/address widths and the MDR sequencer state encoding.
package mdr_mem_unit_pkg;

  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_ADDR_W         = 9;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_e;

  // True while a memory handshake is outstanding.
  function automatic logic is_waiting(input mdr_state_e s);
    return (s == RD_WAIT) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/mdr_timeout_ctr.sv
// Wait-cycle counter for the MDR handshake; tc_c flags the last permitted waiting cycle.
module mdr_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic clear_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Holds at terminal count so a late enable cannot wrap the counter.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdr_mem_unit.sv
// Memory Data Register with req/ack memory sequencer feeding the bus mux MDR input.
// Optional wait timeout enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_unit
  import mdr_mem_unit_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] mdr_d;
  logic [ADDR_W-1:0] addr_d;
  logic              req_d, we_d, done_d, err_d;
  logic              timeout_c;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mdr_mem_unit: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef MDR_TIMEOUT_EN
  logic ctr_clr_c;

  // Restart the wait count whenever a new handshake is launched.
  assign ctr_clr_c = (state_q == IDLE) && (mem_read || mem_write);

  mdr_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (ctr_clr_c),
    .en      (busy),
    .tc_c    (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and next-output logic; ack always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    addr_d  = mem_addr;
    req_d   = mem_req;
    we_d    = mem_we;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          addr_d  = mar_addr;
          we_d    = 1'b0;
          req_d   = 1'b1;
          state_d = RD_WAIT;
        end else if (mem_write) begin
          addr_d  = mar_addr;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = WR_WAIT;
        end else if (mdr_in) begin
          mdr_d = bus_in;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout_c) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_ack || timeout_c) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = !mem_ack;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      mdr_q    <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mdr_q    <= mdr_d;
      mem_addr <= addr_d;
      mem_req  <= req_d;
      mem_we   <= we_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  assign busy      = is_waiting(state_q);
  assign mem_wdata = mdr_q;

endmodule

// File: doc/mdr_mem_unit.md
Name: mdr_mem_unit

Overview:
- Memory Data Register plus memory-handshake sequencer for the lab CPU datapath.
- Sits directly upstream of the bus multiplexer: mdr_q drives the bus mux MDR input, gated by the control unit's MDRout.
- Loads from the common bus, or from memory via a req/ack handshake.
- Writes mdr_q to memory at the address held in MAR.

Parameters:
- DATA_W, 32, width of the bus, MDR and memory data.
- ADDR_W, 9, memory word-address width (512 words).
- TIMEOUT_CYCLES, 16, number of mem_req cycles without ack before abort (used only with MDR_TIMEOUT_EN).

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- bus_in  in  DATA_W  common bus value.
- mdr_in  in  1  load MDR from bus_in (IDLE only).
- mem_read  in  1  start a memory read into MDR.
- mem_write  in  1  start a memory write of MDR.
- mar_addr  in  ADDR_W  address from MAR.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion strobe.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write request, 0 = read request.
- mem_addr  out  ADDR_W  registered request address.
- mem_wdata  out  DATA_W  equals mdr_q.
- mdr_q  out  DATA_W  MDR contents (to bus mux).
- busy  out  1  high in RD_WAIT/WR_WAIT.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

Behaviour:
- **Reset.** Asynchronous while clear_n=0. All outputs and registers go to 0: mdr_q, mem_req, mem_we, mem_addr, done, err, busy. State goes to IDLE.
  - Reset mid-transaction abandons the transaction; mem_req drops immediately.
- **States:** IDLE, RD_WAIT, WR_WAIT.
- **IDLE:**
  - Priority is mem_read > mem_write > mdr_in; lower-priority requests in the same cycle are dropped.
  - mem_read=1: mem_addr<=mar_addr, mem_we<=0, mem_req<=1, go to RD_WAIT.
  - mem_write=1 (no read): mem_addr<=mar_addr, mem_we<=1, mem_req<=1, go to WR_WAIT.
  - mdr_in=1 only: mdr_q<=bus_in; no handshake, no done pulse.
  - mem_ack in IDLE is ignored.
- **RD_WAIT:**
  - mem_req=1 is held.
  - On mem_ack: mdr_q<=mem_rdata, mem_req<=0, done<=1 for one cycle, go to IDLE.
- **WR_WAIT:**
  - mem_req=1, mem_we=1 are held; mem_wdata=mdr_q, stable for the whole transaction.
  - On mem_ack: mem_req<=0, mem_we<=0, done<=1 for one cycle, go to IDLE.
- **While busy:** mdr_in, mem_read and mem_write are ignored; mdr_q changes only via the read ack.
- **Latency:**
  - Request sampled at edge N; mem_req=1 from N+1.
  - Ack sampled at edge M ≥ N+1; mdr_q, done and mem_req=0 visible after M.
  - Minimum request-to-done is 2 cycles.
- **busy** is combinational from state (1 in RD_WAIT/WR_WAIT).
- **Back-to-back:** a new request is accepted in the IDLE cycle in which done is high.
- Without the optional feature, err is constant 0.

Optional Feature:
- Macro: MDR_TIMEOUT_EN.
- **Defined:**
  - An up-counter clears on entry to RD_WAIT/WR_WAIT and increments each waiting cycle.
  - If it reaches TIMEOUT_CYCLES with no ack: mem_req<=0, mem_we<=0, err<=1 and done<=1 for one cycle, go to IDLE; mdr_q unchanged.
  - An ack in the same cycle as terminal count wins (normal completion, err=0).
- **Undefined:** no counter; the FSM waits indefinitely; err is tied 0.

Decomposition:
- Shared CPU package holds:
  - the state enum (IDLE, RD_WAIT, WR_WAIT);
  - DATA_W and ADDR_W defaults, shared with the bus mux and MAR.
- One natural sub-module: mdr_timeout_ctr (clear/enable/terminal-count output), instantiated only under MDR_TIMEOUT_EN.

Test Plan:
- Reset: drive clear_n=0 mid-RD_WAIT -> mdr_q=0, mem_req=0, busy=0 immediately; state is IDLE after release.
- Bus load: bus_in=0xDEADBEEF, mdr_in=1 in IDLE -> mdr_q=0xDEADBEEF next cycle; done stays 0.
- Read: mar_addr=0x055, mem_read pulse, ack after 3 cycles with mem_rdata=0x12345678:
  - mem_addr=0x055 and mem_we=0 while waiting;
  - mdr_q=0x12345678 and done=1 for exactly one cycle;
  - mdr_in pulsed during the wait has no effect.
- Write: mdr_q=0xA5A5A5A5, mar_addr=0x1FF, mem_write pulse, ack after 1 cycle:
  - mem_we=1 and mem_wdata=0xA5A5A5A5 while waiting;
  - done pulse, then mem_req=0.
- Simultaneous request: mem_read=mem_write=mdr_in=1 in IDLE -> read transaction only (mem_we=0); mdr_q unchanged until ack.
- Timeout (MDR_TIMEOUT_EN, TIMEOUT_CYCLES=16): mem_read with no ack:
  - err=done=1 on the 16th waiting cycle; mem_req drops; mdr_q unchanged;
  - a repeat run with ack on the terminal cycle gives err=0.
